// File: rtl/regfile_sb.sv
// Register file with per-entry scoreboard busy bits and a post-reset clear sequencer.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*XLEN-1:0]     rd_data,
  output logic [RD_PORTS-1:0]          rd_busy,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [XLEN-1:0]              wr_data,
  input  logic                         alloc_en,
  input  logic [ADDR_W-1:0]            alloc_addr,
  output logic                         init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic              wr_ok, alloc_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == '1) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_ok    = (state_q == ST_RUN) && wr_en    && (wr_addr    != '0);
  assign alloc_ok = (state_q == ST_RUN) && alloc_en && (alloc_addr != '0);

  // Alloc is applied after writeback so that its busy set wins on a shared address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_q[cnt_q]  <= '0;
        busy_q[cnt_q] <= 1'b0;
      end else begin
        if (wr_ok) begin
          mem_q[wr_addr]  <= wr_data;
          busy_q[wr_addr] <= 1'b0;
        end
        if (alloc_ok) busy_q[alloc_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      ra = rd_addr[p*ADDR_W +: ADDR_W];
      if ((state_q == ST_RUN) && (ra != '0)) begin
        rd_data[p*XLEN +: XLEN] = mem_q[ra];
        rd_busy[p]              = busy_q[ra];
`ifdef REGFILE_SB_BYPASS_EN
        if (wr_en && (wr_addr == ra)) begin
          rd_data[p*XLEN +: XLEN] = wr_data;
          rd_busy[p]              = alloc_en && (alloc_addr == ra);
        end
`endif
      end
    end
  end

  assign init_busy = (state_q == ST_INIT);

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter RD_PORTS, default 2, meaning the number of independent read ports (1..4).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high, sampled on rising clk.
REQ-006 SHALL have port rd_addr  input  RD_PORTS*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
REQ-007 SHALL have port rd_data  output  RD_PORTS*XLEN  read data; port p uses bits [p*XLEN +: XLEN].
REQ-008 SHALL have port rd_busy  output  RD_PORTS  scoreboard busy flag for each read address.
REQ-009 SHALL have port wr_en  input  1  writeback strobe.
REQ-010 SHALL have port wr_addr  input  ADDR_W  writeback destination.
REQ-011 SHALL have port wr_data  input  XLEN  writeback value.
REQ-012 SHALL have port alloc_en  input  1  issue strobe; marks alloc_addr as having a pending producer.
REQ-013 SHALL have port alloc_addr  input  ADDR_W  destination being allocated.
REQ-014 SHALL have port init_busy  output  1  high while the clear sequencer runs.

Function
REQ-015 SHALL provide two states: INIT and RUN.
REQ-016 SHALL, in INIT, clear entry cnt to 0 and busy[cnt] to 0 each cycle; cnt starts at 1 and increments by 1.
REQ-017 SHALL move from INIT to RUN in the cycle after cnt = DEPTH-1 is cleared, so INIT lasts DEPTH-1 cycles.
REQ-018 SHALL hold init_busy = 1 in INIT and 0 in RUN; SHALL ignore wr_en and alloc_en in INIT.
REQ-019 SHALL, in INIT, drive rd_data = 0 and rd_busy = 0 on every port.
REQ-020 SHALL make read ports combinational: rd_data[p] = entry[rd_addr[p]] and rd_busy[p] = busy[rd_addr[p]], with 0 latency.
REQ-021 SHALL hardwire entry 0: reads return 0, busy reads 0, and writes or allocs to address 0 are dropped.
REQ-022 SHALL, in RUN with wr_en and wr_addr != 0, store wr_data and clear busy[wr_addr] at the rising edge.
REQ-023 SHALL, in RUN with alloc_en and alloc_addr != 0, set busy[alloc_addr] at the rising edge.
REQ-024 SHALL, when wr and alloc target the same nonzero address in one cycle, store the data and leave busy set, because alloc takes priority.
REQ-025 SHALL allow any number of read ports to hit the same address and return identical values.
REQ-026 SHALL leave both entry and busy unchanged for an alloc to an already-busy entry; there is no counting.

Reset
REQ-027 SHALL, on rst = 1, enter INIT with cnt = 1 and init_busy = 1 in the following cycle, regardless of the current state.
REQ-028 SHALL, when rst is asserted mid-INIT, restart the clear from cnt = 1.
REQ-029 SHALL hold INIT with cnt = 1 while rst stays high.
REQ-030 SHALL not depend on the contents of any storage before reset, since INIT clears every entry.

Configuration
REQ-031 SHALL recognise macro REGFILE_SB_BYPASS_EN.
REQ-032 SHALL, with REGFILE_SB_BYPASS_EN defined, in RUN with wr_en and wr_addr = rd_addr[p] != 0, drive rd_data[p] = wr_data and rd_busy[p] = 0 in the same cycle.
REQ-033 SHALL keep rd_busy[p] = 1 during that bypass if alloc_en also targets the same address in that cycle.
REQ-034 SHALL, without REGFILE_SB_BYPASS_EN, have reads return the stored value, with a write becoming visible the cycle after its edge.

Verification
REQ-035 SHALL cover: rst for 1 cycle -> init_busy = 1 for exactly DEPTH-1 = 31 cycles; then writing 0xA5A5A5A5 to x7 and reading x7 returns 0xA5A5A5A5.
REQ-036 SHALL cover: alloc x3, then 2 cycles later wr x3 = 0x12345678 -> rd_busy for x3 reads 1 for 2 cycles, then 0; data reads 0x12345678.
REQ-037 SHALL cover: wr x0 = 0xFFFFFFFF plus alloc x0 -> read x0 gives 0, busy 0.
REQ-038 SHALL cover: same-cycle wr and alloc to x5 with data 0xDEADBEEF -> next cycle x5 = 0xDEADBEEF and busy = 1.
REQ-039 SHALL cover: with BYPASS_EN, wr x9 = 0xCAFE0001 while both ports read x9 -> both return 0xCAFE0001 with busy 0 in the same cycle; without BYPASS_EN -> old value that cycle, new value next cycle.
REQ-040 SHALL cover: rst asserted at cnt = 10 of INIT -> INIT restarts and lasts a further 31 cycles after rst drops, with all entries reading 0.
